// File: rtl/simon_pkg.sv
// Shared definitions for the Simon front end: button FSM states, button codes
// and the one-hot helpers that downstream stages reuse.
package simon_pkg;

  localparam int NUM_BUTTONS      = 4;
  localparam int DEFAULT_DEBOUNCE = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } btn_state_t;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t CODE_A = 2'b00;
  localparam btn_code_t CODE_B = 2'b01;
  localparam btn_code_t CODE_C = 2'b10;
  localparam btn_code_t CODE_D = 2'b11;

  // Non-one-hot inputs map to CODE_A; callers qualify with is_one_hot first.
  function automatic btn_code_t encode(input logic [NUM_BUTTONS-1:0] onehot);
    btn_code_t code;
    code = CODE_A;
    case (onehot)
      4'b0001: code = CODE_A;
      4'b0010: code = CODE_B;
      4'b0100: code = CODE_C;
      4'b1000: code = CODE_D;
      default: code = CODE_A;
    endcase
    return code;
  endfunction

  function automatic logic is_one_hot(input logic [NUM_BUTTONS-1:0] v);
    return (v != '0) && ((v & (v - NUM_BUTTONS'(1))) == '0);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, cleared by reset.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces four pushbuttons and emits one registered press pulse per
// press/release cycle, flagging chords through multi_press instead.
module button_conditioner
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  input  logic                   enable,
  output logic [NUM_BUTTONS-1:0] buttons,
  output btn_code_t              press_code,
  output logic                   multi_press,
  output logic                   busy
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BUTTONS-1:0] s;
  logic [NUM_BUTTONS-1:0] cand;
  logic [CNT_W-1:0]       cnt;
  logic                   blocked;
  btn_state_t             state;

  sync_2ff #(.WIDTH(NUM_BUTTONS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (buttons_raw),
    .q     (s)
  );

  // blocked remembers a press seen while disabled, so raising enable during
  // that hold cannot start a debounce until the buttons go idle again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      blocked     <= 1'b0;
      buttons     <= '0;
      press_code  <= CODE_A;
      multi_press <= 1'b0;
      busy        <= 1'b0;
    end else begin
      buttons     <= '0;
      press_code  <= CODE_A;
      multi_press <= 1'b0;
      if (s == '0) begin
        blocked <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (s != '0 && enable && !blocked) begin
            cand  <= s;
            cnt   <= '0;
            state <= PRESS_DB;
            busy  <= 1'b1;
          end else if (s != '0 && !enable) begin
            blocked <= 1'b1;
          end
        end

        PRESS_DB: begin
          if (s != cand || !enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            if (is_one_hot(cand)) begin
              buttons    <= cand;
              press_code <= encode(cand);
            end else begin
              multi_press <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HELD: begin
          if (s == '0) begin
            cnt   <= '0;
            state <= REL_DB;
          end
        end

        REL_DB: begin
          if (s != '0) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// bouncing input, all checked against a run-length reference model.
module tb_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] buttons_raw;
  logic       enable;
  logic [3:0] buttons;
  logic [1:0] press_code;
  logic       multi_press;
  logic       busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .buttons_raw (buttons_raw),
    .enable      (enable),
    .buttons     (buttons),
    .press_code  (press_code),
    .multi_press (multi_press),
    .busy        (busy)
  );

  // Model: a press is accepted after D+1 equal samples, a release after D+1
  // zero samples; m_run counts press samples, m_zeros counts release samples.
  logic [3:0] m_s1, m_s2, m_cand, m_buttons;
  logic [1:0] m_code;
  logic       m_multi, m_held, m_blocked;
  int         m_run, m_zeros;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_cand = '0; m_buttons = '0; m_code = '0;
    m_multi = 1'b0; m_held = 1'b0; m_blocked = 1'b0; m_run = 0; m_zeros = 0;
  endtask

  task automatic model_edge();
    logic [3:0] sv;
    logic       waiting;
    sv = m_s2;
    waiting = !m_held && (m_run == 0);
    m_buttons = '0; m_code = '0; m_multi = 1'b0;
    if (m_held) begin
      if (sv == 0) begin
        m_zeros++;
        if (m_zeros == D + 1) begin m_held = 1'b0; m_zeros = 0; end
      end else m_zeros = 0;
    end else if (m_run == 0) begin
      if (sv != 0 && enable && !m_blocked) begin m_cand = sv; m_run = 1; end
    end else if (sv == m_cand && enable) begin
      m_run++;
      if (m_run == D + 1) begin
        m_run = 0; m_held = 1'b1; m_zeros = 0;
        if ($countones(m_cand) == 1) begin
          m_buttons = m_cand;
          for (int i = 0; i < 4; i++) if (m_cand[i]) m_code = 2'(i);
        end else m_multi = 1'b1;
      end
    end else m_run = 0;
    if (waiting && sv != 0 && !enable) m_blocked = 1'b1;
    if (sv == 0) m_blocked = 1'b0;
    m_s2 = m_s1;
    m_s1 = buttons_raw;
  endtask

  function automatic logic [7:0] dut_vec();
    return {buttons, press_code, multi_press, busy};
  endfunction

  function automatic logic [7:0] model_vec();
    return {m_buttons, m_code, m_multi, (m_held || m_run > 0)};
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) model_reset(); else model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; buttons_raw = 4'b1111; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (dut_vec() !== 8'h00) begin
        bad++; $display("FAIL reset_state cyc=%0d got=%b want=%b", i, dut_vec(), 8'h00);
      end
    end
    buttons_raw = 4'b0000;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL reset_release cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int pulses = 0, at = -1;
    logic [1:0] code = 2'b00;
    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      buttons_raw = (i < 12) ? 4'b0010 : 4'b0000;
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL clean_press cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (buttons != 0) begin pulses++; at = i; code = press_code; end
    end
    total++;
    if (pulses !== 1 || at !== D + 2 || code !== 2'b01) begin
      bad++;
      $display("FAIL clean_pulse count=%0d at=%0d code=%b want count=1 at=%0d code=01", pulses, at, code, D + 2);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL clean_busy got=%b want=0", busy); end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 0; i < 18; i++) begin
      buttons_raw = (i < 10 && (i / 2) % 2 == 0) ? 4'b0100 : 4'b0000;
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL bounce cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (buttons != 0 || multi_press) pulses++;
    end
    total++;
    if (pulses !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL bounce_reject pulses=%0d busy=%b want pulses=0 busy=0", pulses, busy);
    end
  endtask

  task automatic test_multi();
    int multis = 0, pulses = 0;
    for (int i = 0; i < 18; i++) begin
      buttons_raw = (i < 8) ? 4'b0011 : 4'b0000;
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL multi cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (multi_press) multis++;
      if (buttons != 0) pulses++;
    end
    total++;
    if (multis !== 1 || pulses !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL multi_pulse multis=%0d pulses=%0d busy=%b want 1 0 0", multis, pulses, busy);
    end
  endtask

  task automatic test_long_hold();
    int pulses = 0;
    logic [1:0] code = 2'b00;
    for (int i = 0; i < 66; i++) begin
      buttons_raw = (i < 50 || (i >= 51 && i < 54)) ? 4'b1000 : 4'b0000;
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL long_hold cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (buttons != 0) begin pulses++; code = press_code; end
    end
    total++;
    if (pulses !== 1 || code !== 2'b11 || busy !== 1'b0) begin
      bad++; $display("FAIL long_hold_pulse count=%0d code=%b busy=%b want 1 11 0", pulses, code, busy);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0, at = -1;
    logic [1:0] code = 2'b11;
    buttons_raw = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL reset_mid_pre cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (buttons != 0) pulses++;
    end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid_busy got=%b want=1", busy); end
    reset = 1'b1;
    #1;
    model_reset();
    total++;
    if (dut_vec() !== 8'h00) begin
      bad++; $display("FAIL reset_mid_async got=%b want=%b", dut_vec(), 8'h00);
    end
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL reset_mid_post cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (buttons != 0) begin pulses++; at = i; code = press_code; end
    end
    total++;
    if (pulses !== 1 || at !== D + 2 || code !== 2'b00) begin
      bad++; $display("FAIL reset_mid_pulse count=%0d at=%0d code=%b want 1 %0d 00", pulses, at, code, D + 2);
    end
    buttons_raw = 4'b0000;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_enable();
    int early = 0, late = 0;
    enable = 1'b0;
    for (int i = 0; i < 44; i++) begin
      if (i == 10) enable = 1'b1;
      buttons_raw = (i < 20 || (i >= 26 && i < 36)) ? 4'b0001 : 4'b0000;
      step();
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL enable cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      if (buttons != 0) begin
        if (i < 26) early++; else late++;
      end
    end
    total++;
    if (early !== 0 || late !== 1) begin
      bad++; $display("FAIL enable_gate early=%0d late=%0d want 0 1", early, late);
    end
  endtask

  task automatic test_random();
    logic [3:0] cur = 4'b0000;
    int dut_pulses = 0, model_pulses = 0;
    int r;
    logic inv_ok;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        r = $urandom_range(0, 9);
        cur = (r < 4) ? 4'b0000 : (r < 8) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      end
      buttons_raw = cur;
      if ($urandom_range(0, 15) == 0) buttons_raw = cur ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      if ($urandom_range(0, 299) == 0) begin reset = 1'b1; model_reset(); end
      step();
      reset = 1'b0;
      total++;
      if (dut_vec() !== model_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%b want=%b", i, dut_vec(), model_vec());
      end
      inv_ok = !(buttons != 0 && multi_press) && (buttons != 0 || press_code == 2'b00)
               && (buttons == 0 || $countones(buttons) == 1);
      total++;
      if (!inv_ok) begin
        bad++;
        $display("FAIL invariant cyc=%0d buttons=%b code=%b multi=%b want one-hot/zero, exclusive, code 00 when idle",
                 i, buttons, press_code, multi_press);
      end
      if (buttons != 0) dut_pulses++;
      if (m_buttons != 0) model_pulses++;
    end
    total++;
    if (dut_pulses !== model_pulses) begin
      bad++; $display("FAIL random_pulses got=%0d want=%0d", dut_pulses, model_pulses);
    end
    enable = 1'b1;
    buttons_raw = 4'b0000;
    for (int i = 0; i < 10; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    buttons_raw = 4'b0000;
    enable = 1'b1;
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_long_hold();
    test_reset_mid();
    test_enable();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, minimum 2: the number of consecutive stable cycles required to accept a press or a release.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port buttons_raw, input, 4 bits: asynchronous pushbutton levels {D,C,B,A}, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: when high, new presses may be accepted.
REQ-006 The block SHALL have port buttons, output, 4 bits: a one-hot, single-cycle press pulse, registered; it feeds the downstream memory controller.
REQ-007 The block SHALL have port press_code, output, 2 bits: A=00, B=01, C=10, D=11, valid only while buttons != 0.
REQ-008 The block SHALL have port multi_press, output, 1 bit: a single-cycle pulse when an accepted press has more than one bit set.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 buttons_raw SHALL pass through a 2-flop synchronizer; s denotes its output.
REQ-011 The FSM SHALL have the states IDLE, PRESS_DB, HELD and REL_DB.
REQ-012 IDLE: when s != 0 and enable = 1, the FSM SHALL latch cand <= s, set cnt <= 0 and go to PRESS_DB; otherwise it SHALL stay in IDLE.
REQ-013 PRESS_DB: when s != cand or enable = 0, the FSM SHALL return to IDLE with no pulse (bounce reject).
REQ-014 PRESS_DB: otherwise cnt SHALL increment, and when cnt == DEBOUNCE_CYCLES-1 with s == cand the FSM SHALL go to HELD.
REQ-015 On the PRESS_DB->HELD transition with cand one-hot, the block SHALL register buttons <= cand and press_code <= encode(cand) for exactly one cycle.
REQ-016 On the PRESS_DB->HELD transition with cand not one-hot, the block SHALL pulse multi_press for one cycle and keep buttons at 0.
REQ-017 HELD: the FSM SHALL stay while s != 0, with no further pulses regardless of hold length or a change in which buttons are held; when s == 0 it SHALL set cnt <= 0 and go to REL_DB.
REQ-018 REL_DB: when s != 0 the FSM SHALL return to HELD; otherwise cnt SHALL increment, and at cnt == DEBOUNCE_CYCLES-1 the FSM SHALL go to IDLE.
REQ-019 Latency: for a raw change first captured at edge E0 and stable thereafter, buttons SHALL be high during the cycle after edge E0+DEBOUNCE_CYCLES+2.
REQ-020 At most one nonzero pulse (buttons or multi_press) SHALL occur per press/release cycle; buttons and multi_press SHALL never be high together.
REQ-021 Deasserting enable while in HELD or REL_DB SHALL NOT abort release tracking; a press held across the rising edge of enable SHALL NOT generate a pulse until it is released and pressed again.
REQ-022 cnt SHALL have width $clog2(DEBOUNCE_CYCLES) and SHALL never wrap, because the state always changes when cnt reaches DEBOUNCE_CYCLES-1.
REQ-023 press_code SHALL hold 00 whenever buttons == 0.

Reset
REQ-024 Reset SHALL asynchronously force the state to IDLE, both synchronizer stages, cand and cnt to 0, and buttons, press_code, multi_press and busy to 0.
REQ-025 Reset asserted mid-debounce or in HELD SHALL discard the pending press, with no pulse after release of reset.
REQ-026 After reset, a button still held SHALL be treated as a new press.

Structure
REQ-027 The shared package simon_pkg SHALL hold the state enum btn_state_t, the typedef btn_code_t (2 bits), the code constants CODE_A..CODE_D and DEFAULT_DEBOUNCE = 4.
REQ-028 The encode function (one-hot to code) SHALL live in simon_pkg so that downstream stages reuse it.
REQ-029 The synchronizer SHALL be a sub-module sync_2ff (4 bits wide, async reset to 0), instantiated once.

Verification
REQ-030 Clean press test: with DEBOUNCE_CYCLES=4, buttons_raw=0010 held 12 cycles then released -> exactly one buttons=0010 pulse with press_code=01 after edge E0+6, and busy returns to 0 after release debounce.
REQ-031 Bounce reject test: raw 0100 toggling on/off every 2 cycles for 10 cycles, then 0 -> no pulse, FSM returns to IDLE.
REQ-032 Multi-press test: raw 0011 held 8 cycles -> multi_press single pulse, buttons stays 0000.
REQ-033 Long hold test: raw 1000 held 50 cycles, then released with a 1-cycle release glitch back to 1000 -> exactly one pulse (code 11) and no second pulse.
REQ-034 Reset mid-operation test: reset asserted in PRESS_DB at cnt=2 -> all outputs 0 immediately, no pulse; raw still 0001 after reset release -> one pulse, code 00.
REQ-035 Enable gating test: enable=0 with raw 0001 held -> no pulse; enable raised while still held -> no pulse until release and re-press.
